// File: rtl/ctrl_pipe_chain.sv
// Chain of DEPTH pipeline control registers with per-stage stall/flush and bubble insertion.
// Optional performance counters are enabled by defining CTRL_PIPE_PERF_EN.
module ctrl_pipe_chain #(
    parameter int unsigned      WIDTH      = 8,
    parameter int unsigned      DEPTH      = 3,
    parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       ctrl_in,
    input  logic                   valid_in,
    output logic                   in_ready,
    input  logic [DEPTH-1:0]       stall,
    input  logic [DEPTH-1:0]       flush,
    output logic [DEPTH*WIDTH-1:0] ctrl_q,
    output logic [DEPTH-1:0]       valid_q,
    output logic [DEPTH*WIDTH-1:0] ctrl_gated
`ifdef CTRL_PIPE_PERF_EN
    ,
    input  logic                   perf_clr,
    output logic [31:0]            perf_stall_cnt,
    output logic [31:0]            perf_kill_cnt
`endif
);

    logic [DEPTH:0]               hold_c;
    logic [DEPTH:0]               hold_up_c;
    logic [(DEPTH+1)*WIDTH-1:0]   src_ctrl_c;
    logic [DEPTH:0]               src_valid_c;
    logic [DEPTH*WIDTH-1:0]       ctrl_d;
    logic [DEPTH-1:0]             valid_d;

    // Effective hold ripples upstream from the last stage; a flush breaks the chain.
    always_comb begin
        hold_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            hold_c[i] = ~flush[i] & (stall[i] | hold_c[i+1]);
        end
    end

    // Bit i of hold_up_c / word i of src_* is what stage i sees from its upstream neighbour.
    always_comb begin
        hold_up_c   = {hold_c[DEPTH-1:0], 1'b0};
        src_ctrl_c  = {ctrl_q, ctrl_in};
        src_valid_c = {valid_q, valid_in};
        in_ready    = ~hold_c[0];
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        valid_d = valid_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (flush[i]) begin
                ctrl_d[i*WIDTH +: WIDTH] = BUBBLE_VAL;
                valid_d[i]               = 1'b0;
            end else if (hold_c[i]) begin
                ctrl_d[i*WIDTH +: WIDTH] = ctrl_q[i*WIDTH +: WIDTH];
                valid_d[i]               = valid_q[i];
            end else if (hold_up_c[i]) begin
                ctrl_d[i*WIDTH +: WIDTH] = BUBBLE_VAL;
                valid_d[i]               = 1'b0;
            end else begin
                ctrl_d[i*WIDTH +: WIDTH] = src_ctrl_c[i*WIDTH +: WIDTH];
                valid_d[i]               = src_valid_c[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q  <= {DEPTH{BUBBLE_VAL}};
            valid_q <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
        end
    end

    // Invalid stages present the bubble word to consumers.
    always_comb begin
        ctrl_gated = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            ctrl_gated[i*WIDTH +: WIDTH] = valid_q[i] ? ctrl_q[i*WIDTH +: WIDTH] : BUBBLE_VAL;
        end
    end

`ifdef CTRL_PIPE_PERF_EN
    logic [31:0] perf_stall_d, perf_stall_q;
    logic [31:0] perf_kill_d,  perf_kill_q;
    logic        kill_c;

    // Saturating counters; clear wins over increment.
    always_comb begin
        kill_c       = |(flush & valid_q);
        perf_stall_d = perf_stall_q;
        perf_kill_d  = perf_kill_q;
        if (perf_clr) begin
            perf_stall_d = '0;
            perf_kill_d  = '0;
        end else begin
            if (hold_c[0] && (perf_stall_q != 32'hFFFF_FFFF)) perf_stall_d = perf_stall_q + 32'd1;
            if (kill_c && (perf_kill_q != 32'hFFFF_FFFF))     perf_kill_d  = perf_kill_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_q <= '0;
            perf_kill_q  <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_kill_q  <= perf_kill_d;
        end
    end

    always_comb begin
        perf_stall_cnt = perf_stall_q;
        perf_kill_cnt  = perf_kill_q;
    end
`endif

endmodule

// File: tb/tb_ctrl_pipe_chain.sv
// Self-checking bench for ctrl_pipe_chain: directed scenarios plus random stall/flush traffic
// compared against an array-based reference model. Define CTRL_PIPE_PERF_EN to cover the counters.
module tb_ctrl_pipe_chain;
    localparam int unsigned      WIDTH = 8;
    localparam int unsigned      DEPTH = 3;
    localparam logic [WIDTH-1:0] BUB   = 8'h00;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WIDTH-1:0]       ctrl_in;
    logic                   valid_in;
    logic                   in_ready;
    logic [DEPTH-1:0]       stall;
    logic [DEPTH-1:0]       flush;
    logic [DEPTH*WIDTH-1:0] ctrl_q;
    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH*WIDTH-1:0] ctrl_gated;
`ifdef CTRL_PIPE_PERF_EN
    logic                   perf_clr;
    logic [31:0]            perf_stall_cnt;
    logic [31:0]            perf_kill_cnt;
    longint                 m_stall_cnt;
    longint                 m_kill_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] m_ctrl  [DEPTH];
    logic             m_valid [DEPTH];

    ctrl_pipe_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BUBBLE_VAL(BUB)) dut (
        .clk        (clk),
        .reset      (reset),
        .ctrl_in    (ctrl_in),
        .valid_in   (valid_in),
        .in_ready   (in_ready),
        .stall      (stall),
        .flush      (flush),
        .ctrl_q     (ctrl_q),
        .valid_q    (valid_q),
        .ctrl_gated (ctrl_gated)
`ifdef CTRL_PIPE_PERF_EN
        ,
        .perf_clr       (perf_clr),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_kill_cnt  (perf_kill_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // A stage holds if, walking downstream, a stall is met before any flush.
    function automatic bit m_hold(input int i, input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl);
        for (int j = i; j < int'(DEPTH); j++) begin
            if (fl[j]) return 1'b0;
            if (st[j]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] exp_ctrl();
        logic [DEPTH*WIDTH-1:0] r;
        for (int i = 0; i < int'(DEPTH); i++) r[i*WIDTH +: WIDTH] = m_ctrl[i];
        return r;
    endfunction

    function automatic logic [DEPTH*WIDTH-1:0] exp_gated();
        logic [DEPTH*WIDTH-1:0] r;
        for (int i = 0; i < int'(DEPTH); i++) r[i*WIDTH +: WIDTH] = m_valid[i] ? m_ctrl[i] : BUB;
        return r;
    endfunction

    function automatic logic [DEPTH-1:0] exp_valid();
        logic [DEPTH-1:0] r;
        for (int i = 0; i < int'(DEPTH); i++) r[i] = m_valid[i];
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] stage(input int i);
        logic [DEPTH*WIDTH-1:0] v;
        v = ctrl_q;
        return v[i*WIDTH +: WIDTH];
    endfunction

    // One clock: drive inputs, check combinational outputs, advance model, check registers.
    task automatic cycle(input logic [WIDTH-1:0] c, input logic v, input logic [DEPTH-1:0] st,
                         input logic [DEPTH-1:0] fl, input logic rst, input logic clr);
        logic [WIDTH-1:0] n_ctrl  [DEPTH];
        logic             n_valid [DEPTH];
        ctrl_in = c; valid_in = v; stall = st; flush = fl; reset = rst;
`ifdef CTRL_PIPE_PERF_EN
        perf_clr = clr;
`endif
        #1;
        check("in_ready", 64'(in_ready), 64'(!m_hold(0, st, fl)));
        check("ctrl_gated", 64'(ctrl_gated), 64'(exp_gated()));
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (rst || fl[i]) begin
                n_ctrl[i] = BUB; n_valid[i] = 1'b0;
            end else if (m_hold(i, st, fl)) begin
                n_ctrl[i] = m_ctrl[i]; n_valid[i] = m_valid[i];
            end else if (i > 0 && m_hold(i - 1, st, fl)) begin
                n_ctrl[i] = BUB; n_valid[i] = 1'b0;
            end else if (i == 0) begin
                n_ctrl[i] = c; n_valid[i] = v;
            end else begin
                n_ctrl[i] = m_ctrl[i-1]; n_valid[i] = m_valid[i-1];
            end
        end
`ifdef CTRL_PIPE_PERF_EN
        if (rst || clr) begin
            m_stall_cnt = 0; m_kill_cnt = 0;
        end else begin
            bit kill = 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) if (fl[i] && m_valid[i]) kill = 1'b1;
            if (m_hold(0, st, fl) && m_stall_cnt < 64'hFFFF_FFFF) m_stall_cnt++;
            if (kill && m_kill_cnt < 64'hFFFF_FFFF) m_kill_cnt++;
        end
`else
        if (clr) begin end
`endif
        @(posedge clk);
        #1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_ctrl[i] = n_ctrl[i]; m_valid[i] = n_valid[i];
        end
        check("ctrl_q", 64'(ctrl_q), 64'(exp_ctrl()));
        check("valid_q", 64'(valid_q), 64'(exp_valid()));
`ifdef CTRL_PIPE_PERF_EN
        check("perf_stall_cnt", 64'(perf_stall_cnt), 64'(m_stall_cnt));
        check("perf_kill_cnt", 64'(perf_kill_cnt), 64'(m_kill_cnt));
`endif
    endtask

    task automatic go(input logic [WIDTH-1:0] c, input logic v, input logic [DEPTH-1:0] st,
                      input logic [DEPTH-1:0] fl);
        cycle(c, v, st, fl, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b1; ctrl_in = '0; valid_in = 1'b0; stall = '0; flush = '0;
`ifdef CTRL_PIPE_PERF_EN
        perf_clr = 1'b0; m_stall_cnt = 0; m_kill_cnt = 0;
`endif
        for (int i = 0; i < int'(DEPTH); i++) begin
            m_ctrl[i] = BUB; m_valid[i] = 1'b0;
        end
        @(posedge clk); #1;
        check("reset ctrl_q", 64'(ctrl_q), 64'({DEPTH{BUB}}));
        check("reset valid_q", 64'(valid_q), 64'(0));

        // Straight fill: 0x11 reaches stage 2 after the third edge.
        go(8'h11, 1'b1, 3'b000, 3'b000);
        go(8'h22, 1'b1, 3'b000, 3'b000);
        go(8'h33, 1'b1, 3'b000, 3'b000);
        check("fill stage2", 64'(stage(2)), 64'(8'h11));
        check("fill valid", 64'(valid_q), 64'(3'b111));
        go(8'h00, 1'b0, 3'b000, 3'b000);
        check("fill stage2 next", 64'(stage(2)), 64'(8'h22));

        // Hold at stage 1 for two cycles, then release.
        go(8'hB2, 1'b1, 3'b000, 3'b000);
        go(8'hA1, 1'b1, 3'b000, 3'b000);
        for (int k = 0; k < 2; k++) begin
            stall = 3'b010; flush = 3'b000; #1;
            check("hold in_ready", 64'(in_ready), 64'(0));
            go(8'hC3, 1'b1, 3'b010, 3'b000);
            check("hold stage0", 64'(stage(0)), 64'(8'hA1));
            check("hold stage1", 64'(stage(1)), 64'(8'hB2));
            check("bubble stage2", 64'({valid_q[2], stage(2)}), 64'({1'b0, BUB}));
        end
        go(8'hC3, 1'b1, 3'b000, 3'b000);
        check("release stage2", 64'(stage(2)), 64'(8'hB2));

        // Flush beats stall on stage 1.
        go(8'h55, 1'b1, 3'b000, 3'b000);
        go(8'h66, 1'b1, 3'b000, 3'b000);
        stall = 3'b010; flush = 3'b010; #1;
        check("flush in_ready", 64'(in_ready), 64'(1));
        go(8'h77, 1'b1, 3'b010, 3'b010);
        check("flush stage1", 64'({valid_q[1], stage(1)}), 64'({1'b0, BUB}));
        check("flush stage0 loads", 64'(stage(0)), 64'(8'h77));

        // Flush stage 0 against a valid incoming word.
        go(8'h77, 1'b1, 3'b000, 3'b001);
        check("flush0 stage0", 64'({valid_q[0], stage(0)}), 64'({1'b0, BUB}));
        check("flush0 gated", 64'(ctrl_gated[7:0]), 64'(BUB));

        // Reset with a full pipe and all stages stalled.
        go(8'h01, 1'b1, 3'b000, 3'b000);
        go(8'h02, 1'b1, 3'b000, 3'b000);
        go(8'h03, 1'b1, 3'b000, 3'b000);
        cycle(8'h04, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0);
        check("midreset ctrl", 64'(ctrl_q), 64'({DEPTH{BUB}}));
        check("midreset valid", 64'(valid_q), 64'(0));

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            logic [DEPTH-1:0] st, fl;
            for (int b = 0; b < int'(DEPTH); b++) begin
                st[b] = ($urandom_range(0, 3) == 0);
                fl[b] = ($urandom_range(0, 7) == 0);
            end
            cycle(WIDTH'($urandom), 1'($urandom), st, fl,
                  ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
        end

`ifdef CTRL_PIPE_PERF_EN
        // Counter scenario: five stalled cycles and one multi-stage kill.
        go(8'h10, 1'b1, 3'b000, 3'b000);
        go(8'h20, 1'b1, 3'b000, 3'b000);
        cycle(8'h30, 1'b1, 3'b000, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) go(8'h40, 1'b1, 3'b100, 3'b000);
        go(8'h50, 1'b1, 3'b000, 3'b011);
        check("perf stall 5", 64'(perf_stall_cnt), 64'(5));
        check("perf kill 1", 64'(perf_kill_cnt), 64'(1));
        cycle(8'h00, 1'b0, 3'b100, 3'b011, 1'b0, 1'b1);
        check("perf clr stall", 64'(perf_stall_cnt), 64'(0));
        check("perf clr kill", 64'(perf_kill_cnt), 64'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
